// File: rtl/ucode_seq_pkg.sv
// ucode_seq_pkg: shared types and word-layout helpers for the microcode sequencer.
// Every field offset and width is derived from N_IN / N_OUT / DEPTH so the top
// and the bench agree on one layout: end | tsel | tpol | nxt_t | nxt_f | out.
package ucode_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Upper bound on microword width; the extraction helper works on this width.
  localparam int MAX_WORD_W = 512;
  typedef logic [MAX_WORD_W-1:0] wide_t;

  function automatic int f_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int f_iw(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  function automatic int f_word_w(input int n_in, input int n_out, input int depth);
    return 1 + f_iw(n_in) + 1 + 2 * f_aw(depth) + n_out;
  endfunction

  function automatic int f_out_lsb();
    return 0;
  endfunction

  function automatic int f_nxt_f_lsb(input int n_out);
    return n_out;
  endfunction

  function automatic int f_nxt_t_lsb(input int n_out, input int depth);
    return n_out + f_aw(depth);
  endfunction

  function automatic int f_tpol_lsb(input int n_out, input int depth);
    return n_out + 2 * f_aw(depth);
  endfunction

  function automatic int f_tsel_lsb(input int n_out, input int depth);
    return f_tpol_lsb(n_out, depth) + 1;
  endfunction

  function automatic int f_end_lsb(input int n_in, input int n_out, input int depth);
    return f_tsel_lsb(n_out, depth) + f_iw(n_in);
  endfunction

  // Pull a right-justified field of `width` bits starting at `lsb` out of a word.
  function automatic wide_t f_field(input wide_t word, input int lsb, input int width);
    wide_t mask;
    mask = (wide_t'(1) << width) - wide_t'(1);
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/ucode_seq_ram.sv
// ucode_seq_ram: DEPTH x W microcode store. Synchronous write, asynchronous
// read, and a synchronous clear of every word while rst is high.
module ucode_seq_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 54,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Word store: clear-all on reset, otherwise write one word when enabled.
  // NOTE: resetting every word forces this into flops rather than a RAM macro;
  // that is intended here because the sequencer must start from all-zero code.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ucode_seq.sv
// ucode_seq: microcode sequencer. Each RUN cycle fetches mem[pc], drives its
// out field on y, tests one condition input and branches to nxt_t / nxt_f,
// until a word with end=1 returns the FSM to IDLE with a one-cycle done pulse.
// Optional build macro UCODE_SEQ_WDOG_EN adds a step watchdog that aborts a
// run after MAX_STEPS cycles and raises the sticky wd_err flag.
module ucode_seq
  import ucode_seq_pkg::*;
#(
  parameter  int N_IN      = 18,
  parameter  int N_OUT     = 39,
  parameter  int DEPTH     = 16,
  parameter  int MAX_STEPS = 64,
  localparam int AW        = f_aw(DEPTH),
  localparam int IW        = f_iw(N_IN),
  localparam int W         = f_word_w(N_IN, N_OUT, DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [W-1:0]     cfg_wdata,
  input  logic             start,
  input  logic [N_IN-1:0]  x,
  output logic [N_OUT-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    pc,
  output logic             wd_err
);

  localparam int OUT_LSB   = f_out_lsb();
  localparam int NXT_F_LSB = f_nxt_f_lsb(N_OUT);
  localparam int NXT_T_LSB = f_nxt_t_lsb(N_OUT, DEPTH);
  localparam int TPOL_LSB  = f_tpol_lsb(N_OUT, DEPTH);
  localparam int TSEL_LSB  = f_tsel_lsb(N_OUT, DEPTH);
  localparam int END_LSB   = f_end_lsb(N_IN, N_OUT, DEPTH);

  // Any tsel at or above this value selects the "always true" condition.
  localparam logic [IW-1:0] TSEL_LIM = IW'(N_IN);
  // x zero-extended to every tsel code so the index is always in range.
  localparam int XPAD_W = 2 ** IW;

  state_t           r_state;
  logic [AW-1:0]    r_pc;
  logic             r_done;

  logic             w_mem_we;
  logic [W-1:0]     w_rdata;
  logic             w_end;
  logic [IW-1:0]    w_tsel;
  logic             w_tpol;
  logic [AW-1:0]    w_nxt_t;
  logic [AW-1:0]    w_nxt_f;
  logic [N_OUT-1:0] w_out;
  logic [XPAD_W-1:0] w_x_pad;
  logic             w_cond;
  logic [AW-1:0]    w_next_pc;
  logic             w_run;
  logic             w_wd_trip;

  assign w_run = (r_state == RUN);

  // Writes are only honoured while idle so a running program never changes under itself.
  assign w_mem_we = cfg_we && !w_run;

  ucode_seq_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  // Field decode of the word at the registered pc.
  assign w_end   = 1'(f_field(wide_t'(w_rdata), END_LSB, 1));
  assign w_tsel  = IW'(f_field(wide_t'(w_rdata), TSEL_LSB, IW));
  assign w_tpol  = 1'(f_field(wide_t'(w_rdata), TPOL_LSB, 1));
  assign w_nxt_t = AW'(f_field(wide_t'(w_rdata), NXT_T_LSB, AW));
  assign w_nxt_f = AW'(f_field(wide_t'(w_rdata), NXT_F_LSB, AW));
  assign w_out   = N_OUT'(f_field(wide_t'(w_rdata), OUT_LSB, N_OUT));

  assign w_x_pad   = {{(XPAD_W - N_IN){1'b0}}, x};
  assign w_cond    = (w_tsel >= TSEL_LIM) ? 1'b1 : (w_x_pad[w_tsel] ^ w_tpol);
  assign w_next_pc = w_cond ? w_nxt_t : w_nxt_f;

`ifdef UCODE_SEQ_WDOG_EN
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);

  logic [SW-1:0] r_steps;
  logic          r_wd_err;

  // Trip on the MAX_STEPS-th RUN cycle unless that word ends the program anyway.
  assign w_wd_trip = w_run && !w_end && (r_steps == STEP_LAST);

  // Step counter and sticky abort flag; both clear when a new start is accepted.
  // NOTE: sequential state always uses non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_steps  <= '0;
      r_wd_err <= 1'b0;
    end else if (!w_run) begin
      if (start) begin
        r_steps  <= '0;
        r_wd_err <= 1'b0;
      end
    end else begin
      r_steps <= r_steps + 1'b1;
      if (w_wd_trip) begin
        r_wd_err <= 1'b1;
      end
    end
  end

  assign wd_err = r_wd_err;
`else
  assign w_wd_trip = 1'b0;
  assign wd_err    = 1'b0;
`endif

  // Sequencer FSM: accept start in IDLE, step one word per cycle in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_pc <= '0;
          if (start) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_end) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b1;
          end else if (w_wd_trip) begin
            r_state <= IDLE;
            r_pc    <= '0;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pc    <= '0;
        end
      endcase
    end
  end

  assign busy = w_run;
  assign done = r_done;
  assign pc   = r_pc;
  assign y    = w_run ? w_out : '0;

endmodule

// File: tb/tb_ucode_seq.sv
// tb_ucode_seq: directed, hand-computed checks of the microcode sequencer at
// default parameters (N_IN=18, N_OUT=39, DEPTH=16 -> IW=5, AW=4, W=54).
module tb_ucode_seq;

  localparam int N_IN  = 18;
  localparam int N_OUT = 39;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = 54;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [W-1:0]     cfg_wdata;
  logic             start;
  logic [N_IN-1:0]  x;
  logic [N_OUT-1:0] y;
  logic             busy;
  logic             done;
  logic [AW-1:0]    pc;
  logic             wd_err;

  int n_cmp = 0;
  int n_err = 0;

  ucode_seq #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .DEPTH     (DEPTH),
    .MAX_STEPS (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pc        (pc),
    .wd_err    (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: end(1) tsel(5) tpol(1) nxt_t(4) nxt_f(4) out(39).
  function automatic logic [W-1:0] mk(input logic e, input logic [4:0] tsel,
                                      input logic tpol, input logic [3:0] nt,
                                      input logic [3:0] nf, input logic [38:0] out);
    return {e, tsel, tpol, nt, nf, out};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    cfg_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    logic [W-1:0] w1;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; x = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);
    chk("rst_y", y, 0);
    chk("rst_wd_err", wd_err, 0);
    rst = 1'b0;
    step();

    // Basic two-word program: always-true branch 0->1, word 1 ends.
    w1 = mk(1'b1, 5'd0, 1'b0, 4'd0, 4'd0, 39'h1);
    wr(4'd0, mk(1'b0, 5'd31, 1'b0, 4'd1, 4'd0, 39'h1A_A55A_A55A));
    wr(4'd1, w1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_pc", pc, 0);
    chk("t1_c1_y", y, 39'h1A_A55A_A55A);
    chk("t1_c1_done", done, 0);
    step();
    chk("t1_c2_busy", busy, 1);
    chk("t1_c2_pc", pc, 1);
    chk("t1_c2_y", y, 1);
    step();
    chk("t1_c3_busy", busy, 0);
    chk("t1_c3_done", done, 1);
    chk("t1_c3_y", y, 0);
    chk("t1_c3_pc", pc, 0);
    step();
    chk("t1_c4_done", done, 0);

    // Conditional branch on x[2], tpol=0.
    wr(4'd5, mk(1'b1, 5'd0, 1'b0, 4'd0, 4'd0, 39'h55));
    wr(4'd9, mk(1'b1, 5'd0, 1'b0, 4'd0, 4'd0, 39'h99));
    wr(4'd0, mk(1'b0, 5'd2, 1'b0, 4'd5, 4'd9, 39'h7));
    x = 18'h4;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2a_c1_y", y, 7);
    step();
    chk("t2a_c2_pc", pc, 5);
    chk("t2a_c2_y", y, 39'h55);
    step();
    chk("t2a_c3_done", done, 1);
    step();
    x = 18'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t2b_c2_pc", pc, 9);
    chk("t2b_c2_y", y, 39'h99);
    step(); step();

    // Inverted polarity: x[2]=1 with tpol=1 takes the false branch.
    wr(4'd0, mk(1'b0, 5'd2, 1'b1, 4'd5, 4'd9, 39'h7));
    x = 18'h4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t3_c2_pc", pc, 9);
    step(); step();

    // Write and start in the same cycle: first fetch sees the new word.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = mk(1'b0, 5'd31, 1'b0, 4'd5, 4'd9, 39'h3C3C);
    start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    chk("t4_c1_busy", busy, 1);
    chk("t4_c1_y", y, 39'h3C3C);
    step();
    chk("t4_c2_pc", pc, 5);
    step(); step();

    // Chain 0->3->1(end); write and start during RUN are ignored; start held
    // through done restarts one cycle later.
    wr(4'd3, mk(1'b0, 5'd31, 1'b0, 4'd1, 4'd1, 39'h33));
    wr(4'd0, mk(1'b0, 5'd31, 1'b0, 4'd3, 4'd3, 39'h11));
    start = 1'b1;
    step();
    chk("t5_c1_pc", pc, 0);
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = {W{1'b1}};
    step();
    cfg_we = 1'b0;
    chk("t5_c2_pc_no_restart", pc, 3);
    chk("t5_c2_y", y, 39'h33);
    chk("t5_mem1_kept", dut.u_ram.r_mem[1], w1);
    step();
    chk("t5_c3_pc", pc, 1);
    chk("t5_c3_y", y, 1);
    step();
    chk("t5_done_busy", busy, 0);
    chk("t5_done", done, 1);
    step();
    start = 1'b0;
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_pc", pc, 0);
    chk("t5_restart_done", done, 0);
    step(); step(); step();
    chk("t5_second_done", done, 1);
    step();
    chk("t5_mem1_final", dut.u_ram.r_mem[1], w1);

    // Self-looping word: watchdog abort when built in, otherwise runs forever.
    wr(4'd0, mk(1'b0, 5'd31, 1'b0, 4'd0, 4'd0, 39'h77));
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
`ifdef UCODE_SEQ_WDOG_EN
    chk("t6_run_cycles", n, 64);
    chk("t6_wd_err_set", wd_err, 1);
    chk("t6_no_done", done, 0);
    chk("t6_idle_pc", pc, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_wd_err_clr", wd_err, 0);
    chk("t6_rerun_busy", busy, 1);
`else
    chk("t6_run_cycles", n, 100);
    chk("t6_still_busy", busy, 1);
    chk("t6_wd_err_tied", wd_err, 0);
    chk("t6_y_loop", y, 39'h77);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Reset in the third RUN cycle of the 0->3->1 chain: abort, no done, memory cleared.
    wr(4'd1, w1);
    wr(4'd3, mk(1'b0, 5'd31, 1'b0, 4'd1, 4'd1, 39'h33));
    wr(4'd0, mk(1'b0, 5'd31, 1'b0, 4'd3, 4'd3, 39'h11));
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("t7_c3_pc", pc, 1);
    rst = 1'b1;
    step();
    chk("t7_busy", busy, 0);
    chk("t7_pc", pc, 0);
    chk("t7_y", y, 0);
    chk("t7_done", done, 0);
    chk("t7_wd_err", wd_err, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t7_mem%0d", i), dut.u_ram.r_mem[i], 0);
    end
    rst = 1'b0;
    step();
    chk("t7_no_late_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
